vga_sync_decoder: RTL

//  Receive-side counterpart of the VGA timing generator. Samples hsync/vsync,

---
 rtl/vga_sync_decoder.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing recovery: rebuilds x/y/de from hsync/vsync, measures
// line period, hsync width and lines per frame, and reports lock.
module vga_sync_decoder #(
    parameter int H_ACTIVE      = 640,
    parameter int H_FRONT_PORCH = 16,
    parameter int H_SYNC        = 96,
    parameter int H_BACK_PORCH  = 48,
    parameter int V_ACTIVE      = 480,
    parameter int V_FRONT_PORCH = 10,
    parameter int V_SYNC        = 2,
    parameter int V_BACK_PORCH  = 33,
    parameter int LOCK_FRAMES   = 2
) (
    input  logic       pixel_clk,
    input  logic       rst,
    input  logic       hsync,
    input  logic       vsync,
    output logic [9:0] x_count,
    output logic [9:0] y_count,
    output logic       de,
    output logic       locked,
    output logic       frame_start,
    output logic       h_err,
    output logic       v_err
);

    localparam int H_TOTAL  = H_ACTIVE + H_FRONT_PORCH + H_SYNC + H_BACK_PORCH;
    localparam int V_TOTAL  = V_ACTIVE + V_FRONT_PORCH + V_SYNC + V_BACK_PORCH;
    localparam int HS_START = H_ACTIVE + H_FRONT_PORCH;
    localparam int VS_START = V_ACTIVE + V_FRONT_PORCH;

    localparam logic [9:0]  X_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0]  X_LOAD    = 10'(HS_START + 1);
    localparam logic [9:0]  Y_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0]  Y_LOAD    = 10'(VS_START);
    localparam logic [9:0]  X_ACT     = 10'(H_ACTIVE);
    localparam logic [9:0]  Y_ACT     = 10'(V_ACTIVE);
    localparam logic [10:0] PERIOD_OK = 11'(H_TOTAL);
    localparam logic [10:0] WIDTH_OK  = 11'(H_SYNC);
    localparam logic [9:0]  LINES_OK  = 10'(V_TOTAL);
    localparam logic [3:0]  GOOD_LOCK = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        hs_q, vs_q;
    logic [9:0]  x_q, x_d, y_q, y_d;
    logic [10:0] period_q, period_d, width_q, width_d;
    logic [9:0]  lines_q, lines_d;
    logic        period_vld_q, period_vld_d;
    logic [3:0]  good_q, good_d;
    logic        frame_err_q, frame_err_d;
    logic        locked_q, locked_d, de_q, de_d, fs_q, fs_d;
    logic        herr_q, herr_d, verr_q, verr_d;
    logic        hs_rise_s, hs_fall_s, vs_rise_s, err_s;
    logic [3:0]  good_inc_s;

    function automatic logic [10:0] sat_inc11(input logic [10:0] v);
        return (v == 11'h7FF) ? v : v + 11'd1;
    endfunction

    function automatic logic [9:0] sat_inc10(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

    assign hs_rise_s = hsync & ~hs_q;
    assign hs_fall_s = ~hsync & hs_q;
    assign vs_rise_s = vsync & ~vs_q;
    assign err_s     = herr_d | verr_d;

    // Position recovery, timing measurement and error detection
    always_comb begin
        if (hs_rise_s) begin
            x_d = X_LOAD;
        end else if (x_q == X_LAST) begin
            x_d = 10'd0;
        end else begin
            x_d = x_q + 10'd1;
        end

        if (vs_rise_s) begin
            y_d = Y_LOAD;
        end else if (x_q == X_LAST) begin
            y_d = (y_q == Y_LAST) ? 10'd0 : y_q + 10'd1;
        end else begin
            y_d = y_q;
        end

        period_d = hs_rise_s ? 11'd1 : sat_inc11(period_q);
        width_d  = hsync ? sat_inc11(width_q) : 11'd0;

        if (vs_rise_s) begin
            lines_d = hs_rise_s ? 10'd1 : 10'd0;
        end else if (hs_rise_s) begin
            lines_d = sat_inc10(lines_q);
        end else begin
            lines_d = lines_q;
        end

        // The first hs_rise after leaving SEARCH only establishes the reference
        if (state_q == ST_SEARCH) begin
            period_vld_d = 1'b0;
        end else if (hs_rise_s) begin
            period_vld_d = 1'b1;
        end else begin
            period_vld_d = period_vld_q;
        end

        herr_d = (state_q != ST_SEARCH) &&
                 ((hs_rise_s && period_vld_q && (period_q != PERIOD_OK)) ||
                  (hs_fall_s && (width_q != WIDTH_OK)));
        verr_d = (state_q != ST_SEARCH) && vs_rise_s && (lines_q != LINES_OK);
    end

    // Lock FSM next-state and registered-output inputs
    always_comb begin
        state_d     = state_q;
        good_d      = good_q;
        frame_err_d = frame_err_q;
        good_inc_s  = (good_q == 4'hF) ? good_q : good_q + 4'd1;
        case (state_q)
            ST_SEARCH: begin
                if (vs_rise_s) begin
                    state_d     = ST_TRACK;
                    good_d      = 4'd0;
                    frame_err_d = 1'b0;
                end else begin
                    state_d = ST_SEARCH;
                end
            end
            ST_TRACK: begin
                if (err_s) begin
                    state_d     = ST_SEARCH;
                    frame_err_d = 1'b1;
                end else if (vs_rise_s) begin
                    frame_err_d = 1'b0;
                    if (!frame_err_q) begin
                        good_d  = good_inc_s;
                        state_d = (good_inc_s >= GOOD_LOCK) ? ST_LOCKED : ST_TRACK;
                    end else begin
                        good_d = good_q;
                    end
                end else begin
                    state_d = ST_TRACK;
                end
            end
            ST_LOCKED: begin
                if (err_s) begin
                    state_d     = ST_SEARCH;
                    frame_err_d = 1'b1;
                end else begin
                    state_d = ST_LOCKED;
                end
            end
            default: begin
                state_d = ST_SEARCH;
            end
        endcase

        // de is built from next-state values so it stays aligned with x/y
        locked_d = (state_d == ST_LOCKED);
        de_d     = locked_d && (x_d < X_ACT) && (y_d < Y_ACT);
        fs_d     = vs_rise_s;
    end

    // State and counter registers
    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_SEARCH;
            hs_q         <= 1'b0;
            vs_q         <= 1'b0;
            x_q          <= 10'd0;
            y_q          <= 10'd0;
            period_q     <= 11'd0;
            width_q      <= 11'd0;
            lines_q      <= 10'd0;
            period_vld_q <= 1'b0;
            good_q       <= 4'd0;
            frame_err_q  <= 1'b0;
            locked_q     <= 1'b0;
            de_q         <= 1'b0;
            fs_q         <= 1'b0;
            herr_q       <= 1'b0;
            verr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hs_q         <= hsync;
            vs_q         <= vsync;
            x_q          <= x_d;
            y_q          <= y_d;
            period_q     <= period_d;
            width_q      <= width_d;
            lines_q      <= lines_d;
            period_vld_q <= period_vld_d;
            good_q       <= good_d;
            frame_err_q  <= frame_err_d;
            locked_q     <= locked_d;
            de_q         <= de_d;
            fs_q         <= fs_d;
            herr_q       <= herr_d;
            verr_q       <= verr_d;
        end
    end

    assign x_count     = x_q;
    assign y_count     = y_q;
    assign de          = de_q;
    assign locked      = locked_q;
    assign frame_start = fs_q;
    assign h_err       = herr_q;
    assign v_err       = verr_q;

endmodule
